// File: rtl/simple_toggle_pkg.sv
// Shared types and default widths for the en/q/z toggle generator.
package simple_toggle_pkg;

  localparam int DEFAULT_DIV_W = 8;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/simple_toggle_gen_if.sv
// The en/q/z toggle interface: the generator drives it, checkers observe it.
interface simple_toggle_gen_if;

  logic en;
  logic q;
  logic z;

  modport master (output en, output q, output z);
  modport slave  (input  en, input  q, input  z);

endinterface

// File: rtl/simple_toggle_stage.sv
// q/z register pair: z follows q on every enabled edge, which is what makes
// en(t) && q(t) imply z(t+1) == q(t) whenever en stays high.
module simple_toggle_stage (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic toggle,
  output logic q,
  output logic z
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
      z <= 1'b0;
    end else if (en) begin
      z <= q;
      if (toggle) begin
        q <= ~q;
      end
    end
  end

endmodule

// File: rtl/simple_toggle_gen.sv
// Driver side of the en/q/z toggle interface: FSM, phase divider and toggle
// counter, with the q/z pair kept in simple_toggle_stage.
module simple_toggle_gen
  import simple_toggle_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_W-1:0]     div,
  input  logic [CNT_W-1:0]     burst_len,
  simple_toggle_gen_if.master  tif,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     toggle_cnt
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           stateNext;
  logic [DIV_W-1:0] phase;
  logic [DIV_W-1:0] divEff;
  logic [CNT_W-1:0] burst;
  logic [CNT_W-1:0] cntInc;
  logic             accept;
  logic             toggle;
  logic             burstEnd;
  logic             enInt;
  logic             qInt;
  logic             zInt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // stop outranks a due toggle; the burst ends on the edge that reaches burst.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    toggle    = 1'b0;
    burstEnd  = 1'b0;
    cntInc    = (&toggle_cnt) ? toggle_cnt : toggle_cnt + CNT_ONE;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          accept    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        toggle   = (phase == divEff - DIV_ONE) && !stop;
        burstEnd = toggle && (burst != '0) && (cntInc == burst);
        if (stop || burstEnd) begin
          stateNext = FLUSH;
        end
      end
      FLUSH: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase      <= '0;
      divEff     <= '0;
      burst      <= '0;
      toggle_cnt <= '0;
    end else if (accept) begin
      divEff     <= (div == '0) ? DIV_ONE : div;
      burst      <= burst_len;
      phase      <= '0;
      toggle_cnt <= '0;
    end else if (state == RUN && !stop) begin
      if (toggle) begin
        phase      <= '0;
        toggle_cnt <= cntInc;
      end else begin
        phase <= phase + DIV_ONE;
      end
    end
  end

  assign enInt = (state == RUN) || (state == FLUSH);
  assign busy  = (state != IDLE);
  assign done  = (state == FLUSH);

  simple_toggle_stage u_stage (
    .clk    (clk),
    .reset  (reset),
    .en     (enInt),
    .toggle (toggle),
    .q      (qInt),
    .z      (zInt)
  );

  assign tif.en = enInt;
  assign tif.q  = qInt;
  assign tif.z  = zInt;

endmodule

// File: tb/tb_simple_toggle_gen.sv
// Self-checking bench for simple_toggle_gen against a closed-form run model.
module tb_simple_toggle_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic             en;
    logic             q;
    logic             z;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [CNT_W-1:0] burst_len = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] toggle_cnt;

  int   checks = 0;
  int   failures = 0;
  logic curQ = 1'b0;
  logic curZ = 1'b0;
  int   curCnt = 0;

  simple_toggle_gen_if tif ();

  simple_toggle_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .div        (div),
    .burst_len  (burst_len),
    .tif        (tif),
    .busy       (busy),
    .done       (done),
    .toggle_cnt (toggle_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.en   = tif.en;
    o.q    = tif.q;
    o.z    = tif.z;
    o.busy = busy;
    o.done = done;
    o.cnt  = toggle_cnt;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("en=%b q=%b z=%b busy=%b done=%b cnt=%0d",
                     o.en, o.q, o.z, o.busy, o.done, o.cnt);
  endfunction

  // A run of effective divider d, burst b, stop seen on RUN cycle index s
  // (0-based, -1 = never) lasts b*d RUN cycles unless stop cuts it short.
  function automatic int run_len(int d, int b, int s);
    if (b != 0 && (s < 0 || b * d <= s)) return b * d;
    return s + 1;
  endfunction

  function automatic int run_toggles(int d, int b, int s);
    if (b != 0 && (s < 0 || b * d <= s)) return b;
    return s / d;
  endfunction

  // Expected outputs in cycle k after the start was accepted (cycle 0).
  function automatic obs_t model_at(int k, int d, int b, int s, logic q0, logic z0);
    obs_t o;
    int   rl;
    int   te;
    int   t;
    rl = run_len(d, b, s);
    te = run_toggles(d, b, s);
    o  = '0;
    if (k <= rl) begin
      t      = (k - 1) / d;
      o.en   = 1'b1;
      o.busy = 1'b1;
      o.q    = q0 ^ ((t % 2) == 1);
      o.cnt  = CNT_W'(t);
      o.z    = (k == 1) ? z0 : (q0 ^ ((((k - 2) / d) % 2) == 1));
    end else if (k == rl + 1) begin
      o.en   = 1'b1;
      o.busy = 1'b1;
      o.done = 1'b1;
      o.q    = q0 ^ ((te % 2) == 1);
      o.cnt  = CNT_W'(te);
      o.z    = q0 ^ ((((rl - 1) / d) % 2) == 1);
    end else begin
      o.q   = q0 ^ ((te % 2) == 1);
      o.z   = o.q;
      o.cnt = CNT_W'(te);
    end
    return o;
  endfunction

  task automatic test_reset();
    obs_t got;
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = observe();
      checks++;
      if (got !== obs_t'('0)) begin
        failures++;
        $display("[TB] FAIL reset_hold cycle %0d got %s expected all zero", i, fmt(got));
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got = observe();
      checks++;
      if (got !== obs_t'('0)) begin
        failures++;
        $display("[TB] FAIL reset_idle cycle %0d got %s expected all zero", i, fmt(got));
      end
    end
    curQ = 1'b0;
    curZ = 1'b0;
    curCnt = 0;
  endtask

  task automatic test_basic_burst();
    obs_t got;
    obs_t exp;
    @(negedge clk);
    start = 1'b1; div = 8'd2; burst_len = 16'd3;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start    = 1'b0;
      exp.en   = (k <= 7);
      exp.busy = (k <= 7);
      exp.done = (k == 7);
      exp.q    = (k >= 3 && k <= 4) || (k >= 7);
      exp.z    = (k >= 4 && k <= 5) || (k >= 8);
      exp.cnt  = (k >= 7) ? 16'd3 : (k >= 5) ? 16'd2 : (k >= 3) ? 16'd1 : 16'd0;
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL basic_burst cycle %0d got %s expected %s", k, fmt(got), fmt(exp));
      end
    end
    curQ = 1'b1; curZ = 1'b1; curCnt = 3;
  endtask

  task automatic test_div_zero();
    obs_t got;
    obs_t exp;
    int   rl;
    rl = run_len(1, 4, -1);
    @(negedge clk);
    start = 1'b1; stop = 1'b0; div = 8'd0; burst_len = 16'd4;
    for (int k = 1; k <= rl + 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp = model_at(k, 1, 4, -1, curQ, curZ);
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL div_zero cycle %0d got %s expected %s", k, fmt(got), fmt(exp));
      end
    end
    curQ = exp.q; curZ = exp.z; curCnt = int'(exp.cnt);
  endtask

  task automatic test_early_stop();
    obs_t got;
    obs_t exp;
    int   rl;
    rl = run_len(3, 0, 5);
    @(negedge clk);
    start = 1'b1; stop = 1'b0; div = 8'd3; burst_len = 16'd0;
    for (int k = 1; k <= rl + 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp = model_at(k, 3, 0, 5, curQ, curZ);
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL early_stop cycle %0d got %s expected %s", k, fmt(got), fmt(exp));
      end
      stop = (k == 6);
    end
    stop = 1'b0;
    curQ = exp.q; curZ = exp.z; curCnt = int'(exp.cnt);
  endtask

  task automatic test_start_stop_idle();
    obs_t got;
    obs_t exp;
    @(negedge clk);
    start = 1'b1; stop = 1'b1; div = 8'd5; burst_len = 16'd2;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    exp = '0;
    exp.q = curQ; exp.z = curZ; exp.cnt = CNT_W'(curCnt);
    for (int i = 0; i < 3; i++) begin
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL start_stop_idle cycle %0d got %s expected %s", i, fmt(got), fmt(exp));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_during_run();
    obs_t got;
    obs_t exp;
    int   rl;
    rl = run_len(2, 3, -1);
    @(negedge clk);
    start = 1'b1; stop = 1'b0; div = 8'd2; burst_len = 16'd3;
    for (int k = 1; k <= rl + 2; k++) begin
      @(negedge clk);
      exp = model_at(k, 2, 3, -1, curQ, curZ);
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL start_in_run cycle %0d got %s expected %s", k, fmt(got), fmt(exp));
      end
      start     = (k <= rl + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      div       = DIV_W'($urandom_range(0, 7));
      burst_len = CNT_W'($urandom_range(0, 9));
    end
    start = 1'b0;
    curQ = exp.q; curZ = exp.z; curCnt = int'(exp.cnt);
  endtask

  task automatic test_random_runs();
    obs_t got;
    obs_t exp;
    int   dIn;
    int   d;
    int   b;
    int   s;
    int   rl;
    for (int r = 0; r < 14; r++) begin
      dIn = $urandom_range(0, 4);
      d   = (dIn == 0) ? 1 : dIn;
      b   = $urandom_range(0, 5);
      if (b == 0) s = $urandom_range(0, 12);
      else if ($urandom_range(0, 1) == 1) s = -1;
      else s = $urandom_range(0, b * d + 1);
      rl = run_len(d, b, s);
      @(negedge clk);
      start = 1'b1; stop = 1'b0; div = DIV_W'(dIn); burst_len = CNT_W'(b);
      for (int k = 1; k <= rl + 2; k++) begin
        @(negedge clk);
        exp = model_at(k, d, b, s, curQ, curZ);
        got = observe();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("[TB] FAIL random_run %0d (div=%0d burst=%0d stop=%0d) cycle %0d got %s expected %s",
                   r, dIn, b, s, k, fmt(got), fmt(exp));
        end
        start     = (k <= rl + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        div       = DIV_W'($urandom_range(0, 7));
        burst_len = CNT_W'($urandom_range(0, 9));
        stop      = (k == s + 1);
      end
      start = 1'b0; stop = 1'b0;
      curQ = exp.q; curZ = exp.z; curCnt = int'(exp.cnt);
    end
  endtask

  task automatic test_async_reset();
    obs_t got;
    obs_t exp;
    @(negedge clk);
    start = 1'b1; stop = 1'b0; div = 8'd1; burst_len = 16'd0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp = model_at(k, 1, 0, 100, curQ, curZ);
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL pre_reset_run cycle %0d got %s expected %s", k, fmt(got), fmt(exp));
      end
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    got = observe();
    checks++;
    if (got !== obs_t'('0)) begin
      failures++;
      $display("[TB] FAIL async_reset_immediate got %s expected all zero", fmt(got));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = observe();
      checks++;
      if (got !== obs_t'('0)) begin
        failures++;
        $display("[TB] FAIL async_reset_hold cycle %0d got %s expected all zero", i, fmt(got));
      end
    end
    reset = 1'b1;
    @(negedge clk);
    got = observe();
    checks++;
    if (got !== obs_t'('0)) begin
      failures++;
      $display("[TB] FAIL async_reset_release got %s expected all zero", fmt(got));
    end
    curQ = 1'b0; curZ = 1'b0; curCnt = 0;
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_div_zero();
    test_early_stop();
    test_start_stop_idle();
    test_start_during_run();
    test_random_runs();
    test_async_reset();
    test_div_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_toggle_gen.md
Name: simple_toggle_gen

Overview:
- Driver side of the en/q/z toggle interface.
- Generates a gated enable `en`, a data bit `q` that toggles at a programmable rate, and a follower bit `z` that registers `q` on every enabled cycle.
- The interface contract it guarantees:
  - en(t) && q(t) implies !en(t+1) || z(t+1).
  - en(t) && !q(t) implies !en(t+1) || !z(t+1).
- Sits in the SimpleCircuit testbench/demonstrator path. Its outputs feed the toggle assertion checker; reset to that checker is the inverse of this block's reset.

Parameters:
- DIV_W, 8, width of the toggle-period input `div`.
- CNT_W, 16, width of `burst_len` and `toggle_cnt`.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- start  input  1  single-cycle request to begin a run; sampled only in IDLE.
- stop  input  1  request to end a run early; sampled in IDLE and RUN.
- div  input  DIV_W  enabled cycles per q toggle; 0 is treated as 1; latched on accepted start.
- burst_len  input  CNT_W  q toggles per run; 0 means unlimited; latched on accepted start.
- en  output  1  interface enable.
- q  output  1  interface data bit.
- z  output  1  interface follower bit.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse marking run completion.
- toggle_cnt  output  CNT_W  toggles in current/last run; saturates at all-ones.

Behaviour:
- Reset (reset=0, async assert; deassert is synchronous to clk): state=IDLE, en=0, q=0, z=0, busy=0, done=0, toggle_cnt=0, phase=0, latched div/burst=0.
- All outputs are registered or decoded from registered state. No combinational input-to-output path.
- en=1 exactly when state is RUN or FLUSH.
- z rule: on every posedge where en=1, z <= q (pre-edge value). When en=0, z holds.

States:
- IDLE:
  - start=1 && stop=0: latch div_eff = (div==0 ? 1 : div) and burst_len; clear toggle_cnt and phase; go to RUN.
  - Otherwise (including start and stop both high): stay in IDLE.
  - q and z hold their values from the previous run; they are not cleared between runs.
- RUN:
  - If phase == div_eff-1: q <= ~q, phase <= 0, toggle_cnt <= sat(toggle_cnt+1).
  - Otherwise: phase <= phase+1.
  - If burst != 0 and this edge's toggle makes toggle_cnt == burst: next state FLUSH.
  - stop=1: next state FLUSH. No toggle on that edge; stop has priority over a due toggle.
  - start is ignored while in RUN.
- FLUSH:
  - Exactly one cycle. en=1, no toggle, done=1 during this cycle, so z catches the final q.
  - Next state IDLE (en=0 from the following cycle).
  - start and stop are ignored in FLUSH.

Latency and boundaries:
- Start accepted at edge E: en=1 from cycle E+1. First toggle occurs div_eff RUN edges later.
- div=1: q toggles on every RUN edge.
- Unlimited burst (0): runs until stop. toggle_cnt saturates without wrapping and without ending the run.
- Reset mid-run: immediate return to reset values. No done pulse.
- Contract holds at every cycle boundary, including RUN→FLUSH and FLUSH→IDLE.

Decomposition:
- Package simple_toggle_pkg:
  - State typedef: enum logic [1:0] {IDLE, RUN, FLUSH}.
  - Constants DEFAULT_DIV_W=8 and DEFAULT_CNT_W=16.
- One sub-module, simple_toggle_stage: q/z register pair.
  - Inputs: en, toggle.
  - Outputs: q, z.
  - Holds the z <= q on en rule, so the contract lives in one place.
- The FSM, phase counter and toggle counter stay in the top module.

Test Plan:
- Reset then idle: reset low 3 cycles, release, hold start=0 for 10 cycles -> en=q=z=busy=done=0, toggle_cnt=0 throughout.
- Basic burst: div=2, burst_len=3, start pulse at cycle 0 -> en=1 cycles 1–7; q=1 from cycle 3, 0 from 5, 1 from 7; done=1 only at cycle 7; en=0, q=z=1, toggle_cnt=3 at cycle 8.
- div=0 treated as 1, burst_len=4 -> q toggles on each of the first 4 RUN edges; FLUSH follows; toggle_cnt=4; z equals q one cycle after each enabled edge.
- Early stop: div=3, burst_len=0, stop asserted on the RUN cycle where phase=2 -> no toggle on that edge; FLUSH next (done=1); toggle_cnt unchanged; then IDLE.
- Simultaneous start+stop in IDLE -> stays IDLE, busy=0. A start pulse during RUN -> ignored; div/burst are not relatched.
- Async reset mid-run (reset low between clock edges) -> en/q/z/busy clear immediately; no done pulse. Contract assertions pass throughout all scenarios with the checker's reset tied to ~reset.
